// File: rtl/gcd_fsmd_param.sv
// Parametrised GCD engine with a go/busy/done handshake and a per-result work-cycle count.
// MODE selects subtraction Euclid (0) or binary Stein (1); control and datapath share one clocked block.
module gcd_fsmd_param #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             go_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] obeb_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WHILE,
    S_XGTY,
    S_XLTY,
    S_STEP,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [KW-1:0]    k_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] obeb_q;
  logic [CNT_W-1:0] cycles_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] xShl;
  logic [WIDTH-1:0] yShl;
  logic             finish_d;
  logic [WIDTH-1:0] result_d;

  // Termination test and result for the current work cycle; the counter saturates rather than wraps.
  always_comb begin
    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    xShl     = x_q << k_q;
    yShl     = y_q << k_q;
    finish_d = 1'b0;
    result_d = '0;
    if (state_q == S_WHILE) begin
      if (x_q == '0) begin
        finish_d = 1'b1;
        result_d = y_q;
      end else if (y_q == '0) begin
        finish_d = 1'b1;
        result_d = x_q;
      end else if (x_q == y_q) begin
        finish_d = 1'b1;
        result_d = x_q;
      end
    end else if (state_q == S_STEP) begin
      if (x_q == '0) begin
        finish_d = 1'b1;
        result_d = yShl;
      end else if (y_q == '0) begin
        finish_d = 1'b1;
        result_d = xShl;
      end else if (x_q[0] && y_q[0] && (x_q == y_q)) begin
        finish_d = 1'b1;
        result_d = xShl;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      obeb_q   <= '0;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (finish_d) begin
      state_q  <= S_DONE;
      cnt_q    <= cnt_d;
      obeb_q   <= result_d;
      cycles_q <= cnt_d;
      busy_q   <= 1'b1;
      done_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_i) begin
            x_q     <= x_i;
            y_q     <= y_i;
            k_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (MODE == 0) ? S_WHILE : S_STEP;
          end
        end
        S_WHILE: begin
          cnt_q   <= cnt_d;
          state_q <= (x_q > y_q) ? S_XGTY : S_XLTY;
        end
        S_XGTY: begin
          cnt_q   <= cnt_d;
          x_q     <= x_q - y_q;
          state_q <= S_WHILE;
        end
        S_XLTY: begin
          cnt_q   <= cnt_d;
          y_q     <= y_q - x_q;
          state_q <= S_WHILE;
        end
        // Stein: pull out common factors of two first, then strip lone factors, then subtract.
        S_STEP: begin
          cnt_q <= cnt_d;
          if (!x_q[0] && !y_q[0]) begin
            x_q <= x_q >> 1;
            y_q <= y_q >> 1;
            k_q <= k_q + 1'b1;
          end else if (!x_q[0]) begin
            x_q <= x_q >> 1;
          end else if (!y_q[0]) begin
            y_q <= y_q >> 1;
          end else if (x_q > y_q) begin
            x_q <= x_q - y_q;
          end else begin
            y_q <= y_q - x_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign obeb_o   = obeb_q;
  assign cycles_o = cycles_q;

endmodule

// File: tb/tb_gcd_fsmd_param.sv
// Scoreboard bench for gcd_fsmd_param: one Euclid and one Stein instance at WIDTH=8,
// expected results queued at go time and compared when done_o pulses.
module tb_gcd_fsmd_param;

  logic        CLK;
  logic        reset;
  logic        go0, go1;
  logic [7:0]  x0, y0, x1, y1;
  logic        busy0, busy1, done0, done1;
  logic [7:0]  obeb0, obeb1;
  logic [15:0] cycles0, cycles1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0]  obeb;
    logic [15:0] cyc;
    logic        chk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic prevDone0 = 1'b0;
  logic prevDone1 = 1'b0;

  gcd_fsmd_param #(.WIDTH(8), .MODE(0), .CNT_W(16)) dut0 (
    .CLK(CLK), .reset(reset), .go_i(go0), .x_i(x0), .y_i(y0),
    .busy_o(busy0), .done_o(done0), .obeb_o(obeb0), .cycles_o(cycles0)
  );

  gcd_fsmd_param #(.WIDTH(8), .MODE(1), .CNT_W(16)) dut1 (
    .CLK(CLK), .reset(reset), .go_i(go1), .x_i(x1), .y_i(y1),
    .busy_o(busy1), .done_o(done1), .obeb_o(obeb1), .cycles_o(cycles1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] refGcd(input logic [7:0] a, input logic [7:0] b);
    int ua = a;
    int ub = b;
    int t;
    while (ub != 0) begin
      t  = ua % ub;
      ua = ub;
      ub = t;
    end
    return 8'(ua);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic getBusy(input int m);
    return (m == 0) ? busy0 : busy1;
  endfunction

  function automatic logic getDone(input int m);
    return (m == 0) ? done0 : done1;
  endfunction

  // Pop the oldest expectation of an instance when its done pulse is seen.
  task automatic scoreDone(input int m);
    exp_t e;
    logic [7:0]  ob;
    logic [15:0] cy;
    ob = (m == 0) ? obeb0 : obeb1;
    cy = (m == 0) ? cycles0 : cycles1;
    check($sformatf("dut%0d pending expectation", m), ((m == 0) ? q0.size() : q1.size()) != 0, 1);
    if (m == 0 && q0.size() != 0) e = q0.pop_front();
    else if (m == 1 && q1.size() != 0) e = q1.pop_front();
    else return;
    check($sformatf("dut%0d obeb", m), ob, e.obeb);
    if (e.chk) check($sformatf("dut%0d cycles", m), cy, e.cyc);
  endtask

  always @(negedge CLK) begin
    if (!reset) begin
      if (done0) begin
        check("dut0 done single pulse", prevDone0, 0);
        scoreDone(0);
      end
      if (done1) begin
        check("dut1 done single pulse", prevDone1, 0);
        scoreDone(1);
      end
    end
    prevDone0 = done0;
    prevDone1 = done1;
  end

  task automatic pushExp(input int m, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] cyc, input logic chk);
    exp_t e;
    e.obeb = refGcd(a, b);
    e.cyc  = cyc;
    e.chk  = chk;
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic waitDone(input int m, input string tag);
    int n = 0;
    while (!getDone(m) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check({tag, " reached done"}, getDone(m), 1);
  endtask

  // One go pulse, then wait for the result and confirm the block falls back to IDLE.
  task automatic applyStimulus(input int m, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] cyc, input logic chk, input string tag);
    @(negedge CLK);
    if (m == 0) begin go0 = 1'b1; x0 = a; y0 = b; end
    else begin go1 = 1'b1; x1 = a; y1 = b; end
    pushExp(m, a, b, cyc, chk);
    @(negedge CLK);
    if (m == 0) begin go0 = 1'b0; x0 = 8'hA5; y0 = 8'h5A; end
    else begin go1 = 1'b0; x1 = 8'hA5; y1 = 8'h5A; end
    check({tag, " busy after go"}, getBusy(m), 1);
    waitDone(m, tag);
    check({tag, " busy during done"}, getBusy(m), 1);
    @(negedge CLK);
    check({tag, " idle after done"}, {getBusy(m), getDone(m)}, 0);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " dut0 busy"}, busy0, 0);
    check({tag, " dut0 done"}, done0, 0);
    check({tag, " dut0 obeb"}, obeb0, 0);
    check({tag, " dut0 cycles"}, cycles0, 0);
    check({tag, " dut1 busy"}, busy1, 0);
    check({tag, " dut1 done"}, done1, 0);
    check({tag, " dut1 obeb"}, obeb1, 0);
    check({tag, " dut1 cycles"}, cycles1, 0);
  endtask

  logic [7:0] hsX [3] = '{8'd12, 8'd35, 8'd9};
  logic [7:0] hsY [3] = '{8'd18, 8'd14, 8'd27};

  initial begin
    int n;
    reset = 1'b1;
    go0 = 1'b0; x0 = '0; y0 = '0;
    go1 = 1'b0; x1 = '0; y1 = '0;
    #2;
    checkOutput("reset state");
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;

    applyStimulus(0, 8'd12, 8'd8, 16'd5, 1'b1, "m0 12,8");
    applyStimulus(1, 8'd12, 8'd8, 16'd6, 1'b1, "m1 12,8");
    applyStimulus(0, 8'd0, 8'd5, 16'd1, 1'b1, "m0 0,5");
    applyStimulus(1, 8'd0, 8'd5, 16'd1, 1'b1, "m1 0,5");
    applyStimulus(0, 8'd7, 8'd0, 16'd1, 1'b1, "m0 7,0");
    applyStimulus(1, 8'd7, 8'd0, 16'd1, 1'b1, "m1 7,0");
    applyStimulus(0, 8'd0, 8'd0, 16'd1, 1'b1, "m0 0,0");
    applyStimulus(1, 8'd0, 8'd0, 16'd1, 1'b1, "m1 0,0");
    applyStimulus(0, 8'd255, 8'd1, 16'd509, 1'b1, "m0 255,1");
    applyStimulus(1, 8'd255, 8'd255, 16'd1, 1'b1, "m1 255,255");
    applyStimulus(1, 8'd128, 8'd64, 16'd0, 1'b0, "m1 128,64");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 16'd0, 1'b0, "m0 random");
      applyStimulus(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 16'd0, 1'b0, "m1 random");
    end

    // go held high: operands only matter on the accepting IDLE edge, garbage is driven elsewhere.
    @(negedge CLK);
    go0 = 1'b1; x0 = hsX[0]; y0 = hsY[0];
    pushExp(0, hsX[0], hsY[0], 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("hs busy after accept", busy0, 1);
      n = 0;
      while (!done0 && n < 3000) begin
        x0 = 8'($urandom_range(1, 255));
        y0 = 8'($urandom_range(1, 255));
        @(negedge CLK);
        n++;
      end
      check("hs reached done", done0, 1);
      x0 = 8'd200; y0 = 8'd100;
      @(negedge CLK);
      check("hs idle gap", {busy0, done0}, 0);
      if (i < 2) begin
        x0 = hsX[i + 1]; y0 = hsY[i + 1];
        pushExp(0, hsX[i + 1], hsY[i + 1], 16'd0, 1'b0);
      end else begin
        go0 = 1'b0;
      end
    end
    @(negedge CLK);
    check("hs stays idle", busy0, 0);

    // Reset lands between clock edges partway through a long Euclid run.
    @(negedge CLK);
    go0 = 1'b1; x0 = 8'd255; y0 = 8'd1;
    pushExp(0, 8'd255, 8'd1, 16'd509, 1'b1);
    @(negedge CLK);
    go0 = 1'b0;
    repeat (20) @(negedge CLK);
    check("pre-reset busy", busy0, 1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async reset");
    q0.delete();
    @(negedge CLK);
    reset = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("post-reset idle", busy0, 0);
    end
    applyStimulus(0, 8'd9, 8'd6, 16'd5, 1'b1, "m0 9,6 after reset");

    repeat (2) @(negedge CLK);
    check("dut0 queue drained", q0.size(), 0);
    check("dut1 queue drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
